reg_load_arbiter: RTL and testbench

REG_LOAD_ARBITER -- requirements
Module: reg_load_arbiter

---
 rtl/reg_load_arbiter.sv | 144 ++++++++++++++
 tb/tb_reg_load_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_load_arbiter
// Purpose  : Arbitrates N requesters for one shared register. A winning
//            requester's word is presented on DOut with a one-cycle active-low
//            LD strobe, followed by a one-cycle Ack pulse back to the winner.
//            All state updates occur on the falling edge of Clk.
// Options  : REG_ARB_FIXED_PRIORITY_EN - when defined, the lowest asserted
//            index always wins and the round-robin pointer is not built.
//            When undefined, arbitration is round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module reg_load_arbiter #(
   parameter  int DataWidth  = 8,
   parameter  int Requesters = 4,
   localparam int IdWidth    = $clog2(Requesters)
) (
   input  logic                            Clk,
   input  logic                            Reset,
   input  logic [Requesters-1:0]           Req,
   input  logic [Requesters*DataWidth-1:0] Data,
   output logic [Requesters-1:0]           Ack,
   output logic                            LD,
   output logic [DataWidth-1:0]            DOut,
   output logic [IdWidth-1:0]              GrantId,
   output logic                            Busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic                   ld_d;
   logic                   busy_d;
   logic [Requesters-1:0]  ack_d;
   logic [DataWidth-1:0]   dout_d;
   logic [IdWidth-1:0]     grant_d;
   logic [IdWidth-1:0]     winner;

   // Index of the lowest set bit; zero when nothing is set.
   function automatic logic [IdWidth-1:0] lowest_set(input logic [Requesters-1:0] vec);
      logic [IdWidth-1:0] idx;
      idx = '0;
      for (int i = Requesters - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IdWidth'(i);
         end
      end
      return idx;
   endfunction

`ifdef REG_ARB_FIXED_PRIORITY_EN

   // Fixed priority: the lowest asserted index wins every time.
   always_comb begin
      winner = lowest_set(Req);
   end

`else

   logic [IdWidth-1:0]    ptr_q;
   logic [Requesters-1:0] upper_mask;
   logic [Requesters-1:0] upper_req;

   // Round robin: prefer requests above the last grant, else wrap to the lowest.
   always_comb begin
      upper_mask = '0;
      for (int i = 0; i < Requesters; i++) begin
         if (i > int'(ptr_q)) begin
            upper_mask[i] = 1'b1;
         end
      end
      upper_req = Req & upper_mask;
      winner    = (|upper_req) ? lowest_set(upper_req) : lowest_set(Req);
   end

   // Last-granted pointer; reset to the top index so index 0 goes first.
   always_ff @(negedge Clk) begin
      if (Reset) begin
         ptr_q <= IdWidth'(Requesters - 1);
      end else if (state_q == S_IDLE && |Req) begin
         ptr_q <= winner;
      end
   end

`endif

   // Next state and next registered output values.
   always_comb begin
      state_d = state_q;
      ld_d    = 1'b1;
      busy_d  = 1'b0;
      ack_d   = '0;
      dout_d  = DOut;
      grant_d = GrantId;
      case (state_q)
         S_IDLE: begin
            if (|Req) begin
               state_d = S_LOAD;
               ld_d    = 1'b0;
               busy_d  = 1'b1;
               dout_d  = Data[int'(winner)*DataWidth +: DataWidth];
               grant_d = winner;
            end
         end
         S_LOAD: begin
            state_d = S_ACK;
            busy_d  = 1'b1;
            ack_d   = Requesters'(1) << GrantId;
         end
         S_ACK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any transaction in flight.
   always_ff @(negedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         LD      <= 1'b1;
         Busy    <= 1'b0;
         Ack     <= '0;
         DOut    <= '0;
         GrantId <= '0;
      end else begin
         state_q <= state_d;
         LD      <= ld_d;
         Busy    <= busy_d;
         Ack     <= ack_d;
         DOut    <= dout_d;
         GrantId <= grant_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_load_arbiter
// Purpose  : Self-checking bench for reg_load_arbiter with a transaction-level
//            reference model, directed scenarios and randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_load_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           Clk;
   logic           Reset;
   logic [N-1:0]   Req;
   logic [N*W-1:0] Data;
   logic [N-1:0]   Ack;
   logic           LD;
   logic [W-1:0]   DOut;
   logic [1:0]     GrantId;
   logic           Busy;

   int n_checks = 0;
   int n_fail   = 0;

   reg_load_arbiter #(.DataWidth(W), .Requesters(N)) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .Data(Data), .Ack(Ack),
      .LD(LD), .DOut(DOut), .GrantId(GrantId), .Busy(Busy)
   );

   initial begin
      Clk = 1'b1;
      forever #5 Clk = ~Clk;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Shared register loaded on the falling edge while LD is low.
   logic [W-1:0] shreg = '0;
   always @(negedge Clk) begin
      if (!LD) shreg <= DOut;
   end

   // Reference model: cycles remaining in the current transaction
   // (2 = strobe cycle, 1 = acknowledge cycle, 0 = no transaction).
   int           cnt     = 0;
   int           m_ptr   = N - 1;
   logic [W-1:0] m_dout  = '0;
   int           m_gid   = 0;
   logic [W-1:0] m_reg   = '0;
   logic         started = 1'b0;
   logic         exp_ld;
   logic         exp_busy;
   logic [N-1:0] exp_ack;

   always @(negedge Clk) begin
      int win;
      if (cnt == 2) m_reg = m_dout;
      if (Reset) begin
         cnt = 0; m_ptr = N - 1; m_dout = '0; m_gid = 0;
      end else if (cnt == 0) begin
         if (Req != '0) begin
            win = -1;
`ifdef REG_ARB_FIXED_PRIORITY_EN
            for (int k = 0; k < N; k++)
               if (win < 0 && Req[k]) win = k;
`else
            for (int k = 1; k <= N; k++)
               if (win < 0 && Req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
`endif
            m_ptr  = win;
            m_gid  = win;
            m_dout = Data[win*W +: W];
            cnt    = 2;
         end
      end else begin
         cnt = cnt - 1;
      end
      exp_ld   = (cnt != 2);
      exp_busy = (cnt != 0);
      exp_ack  = (cnt == 1) ? N'(1 << m_gid) : '0;
      started  = 1'b1;
   end

   // Every-cycle comparison on the rising edge, away from the active edge.
   always @(posedge Clk) begin
      if (started) begin
         chk("ld",      {31'd0, LD},      {31'd0, exp_ld});
         chk("busy",    {31'd0, Busy},    {31'd0, exp_busy});
         chk("ack",     32'(Ack),         32'(exp_ack));
         chk("dout",    32'(DOut),        32'(m_dout));
         chk("grantid", 32'(GrantId),     m_gid);
         chk("shreg",   32'(shreg),       32'(m_reg));
      end
   end

   task automatic tick();
      @(negedge Clk);
      #1;
   endtask

   initial begin
      int ld_pulses;
      Reset = 1'b1;
      Req   = '0;
      Data  = '0;
      tick();
      tick();
      chk("rst_ld",   {31'd0, LD},   32'd1);
      chk("rst_ack",  32'(Ack),      32'd0);
      chk("rst_busy", {31'd0, Busy}, 32'd0);
      chk("rst_dout", 32'(DOut),     32'd0);
      chk("rst_gid",  32'(GrantId),  32'd0);
      Reset = 1'b0;

      // Single request from requester 0.
      Req = 4'b0001;
      Data[7:0] = 8'hA5;
      tick();
      chk("t1_ld",   {31'd0, LD},   32'd0);
      chk("t1_dout", 32'(DOut),     32'hA5);
      chk("t1_gid",  32'(GrantId),  32'd0);
      chk("t1_busy", {31'd0, Busy}, 32'd1);
      tick();
      chk("t1_ld2",   {31'd0, LD},   32'd1);
      chk("t1_ack",   32'(Ack),      32'h1);
      chk("t1_busy2", {31'd0, Busy}, 32'd1);
      Req = '0;
      tick();
      chk("t1_ack0",  32'(Ack),      32'd0);
      chk("t1_busy0", {31'd0, Busy}, 32'd0);
      chk("t1_reg",   32'(shreg),    32'hA5);

      // All four requesting, each dropping on its Ack.
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      Data = 32'h44332211;
      Req  = 4'b1111;
      for (int g = 0; g < N; g++) begin
         tick();
         chk("rr_gid", 32'(GrantId), g);
         chk("rr_ld",  {31'd0, LD},  32'd0);
         tick();
         chk("rr_ack", 32'(Ack), 32'(1 << g));
         Req[g] = 1'b0;
         tick();
         chk("rr_idle", {31'd0, Busy}, 32'd0);
      end

      // Data changes after the grant edge must not disturb DOut.
      Data[23:16] = 8'h3C;
      Req = 4'b0100;
      tick();
      chk("hold_gid", 32'(GrantId), 32'd2);
      chk("hold_d0",  32'(DOut),    32'h3C);
      Data[23:16] = 8'hFF;
      Req = '0;
      tick();
      chk("hold_d1", 32'(DOut), 32'h3C);
      tick();
      chk("hold_d2", 32'(DOut),  32'h3C);
      chk("hold_rg", 32'(shreg), 32'h3C);

      // Requester 1 drops Req during LOAD; transaction still completes.
      ld_pulses = 0;
      Req = 4'b0010;
      tick();
      if (!LD) ld_pulses++;
      Req = '0;
      tick();
      if (!LD) ld_pulses++;
      chk("drop_ack", 32'(Ack), 32'h2);
      tick();
      if (!LD) ld_pulses++;
      tick();
      if (!LD) ld_pulses++;
      chk("drop_pulses", ld_pulses, 32'd1);

      // Reset during LOAD aborts with no Ack.
      Req = 4'b0001;
      Data[7:0] = 8'h77;
      tick();
      chk("abort_ld0", {31'd0, LD}, 32'd0);
      Reset = 1'b1;
      tick();
      chk("abort_ld",   {31'd0, LD},   32'd1);
      chk("abort_ack",  32'(Ack),      32'd0);
      chk("abort_dout", 32'(DOut),     32'd0);
      chk("abort_gid",  32'(GrantId),  32'd0);
      chk("abort_busy", {31'd0, Busy}, 32'd0);
      Reset = 1'b0;
      Req   = '0;
      tick();
      chk("abort_noack", 32'(Ack), 32'd0);

      // Randomized traffic checked by the model every cycle.
      for (int c = 0; c < 3000; c++) begin
         tick();
         Reset = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < N; i++) begin
            if (exp_ack[i]) Req[i] = 1'b0;
            else if (!Req[i] && $urandom_range(0, 3) == 0) Req[i] = 1'b1;
            else if (Req[i] && $urandom_range(0, 29) == 0) Req[i] = 1'b0;
            if ($urandom_range(0, 2) == 0) Data[i*W +: W] = W'($urandom);
         end
      end
      Reset = 1'b0;
      Req   = '0;
      tick();
      tick();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
